// File: rtl/ex_id_bypass_pkg.sv
// ============================================================================
// Module  : ex_id_bypass_pkg
// Brief   : Shared widths and constants for the EX->ID scoreboard/bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

package ex_id_bypass_pkg;
    localparam int unsigned IMM_WIDTH = 64;
    localparam int unsigned XLEN_DEF  = IMM_WIDTH;
    localparam int unsigned RA_W_DEF  = 5;
    localparam int unsigned X0_IDX    = 0;
endpackage

`default_nettype wire

// File: rtl/ex_id_bypass_mux.sv
// ============================================================================
// Module  : bypass_mux
// Brief   : Per-source operand select; forwarding paths only with EX_ID_BYPASS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module bypass_mux
    import ex_id_bypass_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] src_i,
    input  logic            use_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic            ex_valid_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            hold_valid_i,
    input  logic [RA_W-1:0] hold_rd_i,
    input  logic [XLEN-1:0] hold_data_i,
    input  logic            wb_valid_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            busy_i,
    output logic [XLEN-1:0] data_o,
    output logic            unresolved_o
);
    localparam logic [RA_W-1:0] c_x0 = RA_W'(X0_IDX);

`ifndef EX_ID_BYPASS_EN
    logic unused_cand;
    assign unused_cand = ^{ex_valid_i, ex_rd_i, ex_data_i, hold_valid_i, hold_rd_i,
                           hold_data_i, wb_valid_i, wb_rd_i, wb_data_i};
`endif

    always_comb begin
        data_o       = rdata_i;
        unresolved_o = 1'b0;
        if (src_i == c_x0) begin
            data_o = '0;
`ifdef EX_ID_BYPASS_EN
        end else if (ex_valid_i && ex_rd_i == src_i) begin
            data_o = ex_data_i;
        end else if (hold_valid_i && hold_rd_i == src_i) begin
            data_o = hold_data_i;
        end else if (wb_valid_i && wb_rd_i == src_i) begin
            data_o = wb_data_i;
`endif
        end else begin
            unresolved_o = use_i & busy_i;
        end
    end
endmodule

`default_nettype wire

// File: rtl/ex_id_bypass.sv
// ============================================================================
// Module  : ex_id_bypass
// Brief   : Destination scoreboard + EX/WB operand bypass to ID (EX_ID_BYPASS_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_id_bypass
    import ex_id_bypass_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid_ID,
    input  logic [RA_W-1:0] issue_rd_ID,
    input  logic            issue_wen_ID,
    input  logic            issue_load_ID,
    input  logic [RA_W-1:0] rs1_ID,
    input  logic [RA_W-1:0] rs2_ID,
    input  logic            rs1_use_ID,
    input  logic            rs2_use_ID,
    input  logic [XLEN-1:0] rdata_1_ID,
    input  logic [XLEN-1:0] rdata_2_ID,
    input  logic            ex_valid,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data_1,
    output logic [XLEN-1:0] fwd_data_2,
    output logic            stall_ID
);
    localparam int unsigned     NREG = 1 << RA_W;
    localparam logic [RA_W-1:0] c_x0 = RA_W'(X0_IDX);

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] is_load_q, is_load_d;
    logic            w_unres_1, w_unres_2, w_issue;
    logic [XLEN-1:0] w_data_1, w_data_2;
    logic            w_hold_valid;
    logic [RA_W-1:0] w_hold_rd;
    logic [XLEN-1:0] w_hold_data;
    logic            unused_load;

    assign unused_load = ^is_load_q;

`ifdef EX_ID_BYPASS_EN
    logic            hold_valid_q;
    logic [RA_W-1:0] hold_rd_q;
    logic [XLEN-1:0] hold_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= ex_valid;
            hold_rd_q    <= ex_rd;
            hold_data_q  <= ex_data;
        end
    end

    assign w_hold_valid = hold_valid_q;
    assign w_hold_rd    = hold_rd_q;
    assign w_hold_data  = hold_data_q;
`else
    assign w_hold_valid = 1'b0;
    assign w_hold_rd    = '0;
    assign w_hold_data  = '0;
`endif

    // Reset forces a transparent register-file read path regardless of bypass inputs.
    assign stall_ID   = rst & (w_unres_1 | w_unres_2);
    assign fwd_data_1 = rst ? w_data_1 : rdata_1_ID;
    assign fwd_data_2 = rst ? w_data_2 : rdata_2_ID;
    assign w_issue    = issue_valid_ID & issue_wen_ID & (issue_rd_ID != c_x0) & ~stall_ID;

    // Retire first so a same-cycle issue to that rd keeps the entry busy.
    always_comb begin
        busy_d    = busy_q;
        is_load_d = is_load_q;
        if (wb_valid && wb_rd != c_x0) begin
            busy_d[wb_rd]    = 1'b0;
            is_load_d[wb_rd] = 1'b0;
        end
        if (w_issue) begin
            busy_d[issue_rd_ID]    = 1'b1;
            is_load_d[issue_rd_ID] = issue_load_ID;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= '0;
            is_load_q <= '0;
        end else begin
            busy_q    <= busy_d;
            is_load_q <= is_load_d;
        end
    end

    bypass_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_mux_1 (
        .src_i(rs1_ID), .use_i(rs1_use_ID), .rdata_i(rdata_1_ID),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
        .hold_valid_i(w_hold_valid), .hold_rd_i(w_hold_rd), .hold_data_i(w_hold_data),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .busy_i(busy_q[rs1_ID]), .data_o(w_data_1), .unresolved_o(w_unres_1)
    );

    bypass_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_mux_2 (
        .src_i(rs2_ID), .use_i(rs2_use_ID), .rdata_i(rdata_2_ID),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
        .hold_valid_i(w_hold_valid), .hold_rd_i(w_hold_rd), .hold_data_i(w_hold_data),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .busy_i(busy_q[rs2_ID]), .data_o(w_data_2), .unresolved_o(w_unres_2)
    );
endmodule

`default_nettype wire

// File: tb/tb_ex_id_bypass.sv
// ============================================================================
// Module  : tb_ex_id_bypass
// Brief   : Directed self-checking bench for ex_id_bypass (either build of EX_ID_BYPASS_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_id_bypass;
`ifdef EX_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_ID, issue_wen_ID, issue_load_ID;
    logic [4:0]  issue_rd_ID, rs1_ID, rs2_ID, ex_rd, wb_rd;
    logic        rs1_use_ID, rs2_use_ID, ex_valid, wb_valid;
    logic [63:0] rdata_1_ID, rdata_2_ID, ex_data, wb_data;
    logic [63:0] fwd_data_1, fwd_data_2;
    logic        stall_ID;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_id_bypass dut (
        .clk(clk), .rst(rst),
        .issue_valid_ID(issue_valid_ID), .issue_rd_ID(issue_rd_ID),
        .issue_wen_ID(issue_wen_ID), .issue_load_ID(issue_load_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_use_ID(rs1_use_ID), .rs2_use_ID(rs2_use_ID),
        .rdata_1_ID(rdata_1_ID), .rdata_2_ID(rdata_2_ID),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2), .stall_ID(stall_ID)
    );

    task automatic idle();
        issue_valid_ID = 0; issue_wen_ID = 0; issue_load_ID = 0; issue_rd_ID = 0;
        rs1_ID = 0; rs2_ID = 0; rs1_use_ID = 0; rs2_use_ID = 0;
        rdata_1_ID = 0; rdata_2_ID = 0;
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        issue_valid_ID = 1; issue_wen_ID = 1; issue_load_ID = ld; issue_rd_ID = rd;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        rs1_ID = 3; rs1_use_ID = 1; rdata_1_ID = 64'h11;
        rs2_ID = 0; rs2_use_ID = 1; rdata_2_ID = 64'h22;
        ex_valid = 1; ex_rd = 3; ex_data = 64'h99;
        issue(5'd3, 1'b0);
        #2;
        n_chk++; if (fwd_data_1 !== 64'h11) begin n_fail++; $display("FAIL reset_fwd1: got %h expected %h", fwd_data_1, 64'h11); end
        n_chk++; if (fwd_data_2 !== 64'h22) begin n_fail++; $display("FAIL reset_fwd2: got %h expected %h", fwd_data_2, 64'h22); end
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_ID); end
        tick(); tick();
        rst = 1'b1;
        idle();
    endtask

    task automatic test_alu_chain();
        logic [63:0] e;
        idle(); issue(5'd5, 1'b0); tick();
        idle(); rs1_ID = 5; rs1_use_ID = 1; rdata_1_ID = 64'hAAAA;
        ex_valid = 1; ex_rd = 5; ex_data = 64'h10; #1;
        e = BYP ? 64'h10 : 64'hAAAA;
        n_chk++; if (fwd_data_1 !== e) begin n_fail++; $display("FAIL alu_fwd1: got %h expected %h", fwd_data_1, e); end
        n_chk++; if (stall_ID !== !BYP) begin n_fail++; $display("FAIL alu_stall: got %b expected %b", stall_ID, !BYP); end
        tick();
    endtask

    task automatic test_distance2();
        logic [63:0] e;
        idle(); ex_valid = 1; ex_rd = 5; ex_data = 64'h20; #1;
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL d2_nouse_stall: got %b expected 0", stall_ID); end
        tick();
        idle(); rs1_ID = 5; rs1_use_ID = 1; rdata_1_ID = 64'hAAAA; #1;
        e = BYP ? 64'h20 : 64'hAAAA;
        n_chk++; if (fwd_data_1 !== e) begin n_fail++; $display("FAIL d2_hold_fwd1: got %h expected %h", fwd_data_1, e); end
        n_chk++; if (stall_ID !== !BYP) begin n_fail++; $display("FAIL d2_hold_stall: got %b expected %b", stall_ID, !BYP); end
        tick();
        idle(); rs1_ID = 5; rs1_use_ID = 1; rdata_1_ID = 64'hAAAA;
        wb_valid = 1; wb_rd = 5; wb_data = 64'h20; #1;
        n_chk++; if (fwd_data_1 !== e) begin n_fail++; $display("FAIL d2_wb_fwd1: got %h expected %h", fwd_data_1, e); end
        n_chk++; if (stall_ID !== !BYP) begin n_fail++; $display("FAIL d2_wb_stall: got %b expected %b", stall_ID, !BYP); end
        tick();
        idle(); rs1_ID = 5; rs1_use_ID = 1; rdata_1_ID = 64'hBBBB; #1;
        n_chk++; if (fwd_data_1 !== 64'hBBBB) begin n_fail++; $display("FAIL d2_retired_fwd1: got %h expected %h", fwd_data_1, 64'hBBBB); end
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL d2_retired_stall: got %b expected 0", stall_ID); end
        tick();
    endtask

    task automatic test_load_use();
        logic [63:0] e;
        idle(); issue(5'd7, 1'b1); tick();
        for (int c = 0; c < 2; c++) begin
            idle(); rs2_ID = 7; rs2_use_ID = 1; rdata_2_ID = 64'h1234;
            issue(5'd11, 1'b0); #1;
            n_chk++; if (stall_ID !== 1'b1) begin n_fail++; $display("FAIL lu_stall_c%0d: got %b expected 1", c, stall_ID); end
            if (c == 0) begin
                n_chk++; if (fwd_data_2 !== 64'h1234) begin n_fail++; $display("FAIL lu_stall_fwd2: got %h expected %h", fwd_data_2, 64'h1234); end
            end
            tick();
        end
        idle(); rs2_ID = 7; rs2_use_ID = 1; rdata_2_ID = 64'h1234;
        wb_valid = 1; wb_rd = 7; wb_data = 64'hDEAD; #1;
        e = BYP ? 64'hDEAD : 64'h1234;
        n_chk++; if (fwd_data_2 !== e) begin n_fail++; $display("FAIL lu_wb_fwd2: got %h expected %h", fwd_data_2, e); end
        n_chk++; if (stall_ID !== !BYP) begin n_fail++; $display("FAIL lu_wb_stall: got %b expected %b", stall_ID, !BYP); end
        tick();
        idle(); rs2_ID = 7; rs2_use_ID = 1; rdata_2_ID = 64'h5678;
        rs1_ID = 11; rs1_use_ID = 1; rdata_1_ID = 64'h99; #1;
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL lu_after_stall: got %b expected 0", stall_ID); end
        n_chk++; if (fwd_data_2 !== 64'h5678) begin n_fail++; $display("FAIL lu_after_fwd2: got %h expected %h", fwd_data_2, 64'h5678); end
        n_chk++; if (fwd_data_1 !== 64'h99) begin n_fail++; $display("FAIL lu_ignored_issue_fwd1: got %h expected %h", fwd_data_1, 64'h99); end
        tick();
    endtask

    task automatic test_same_cycle();
        idle(); issue(5'd9, 1'b0); tick();
        idle(); issue(5'd9, 1'b0); wb_valid = 1; wb_rd = 9; wb_data = 64'h77; tick();
        idle(); rs1_ID = 9; rs1_use_ID = 1; rdata_1_ID = 64'h31; #1;
        n_chk++; if (stall_ID !== 1'b1) begin n_fail++; $display("FAIL same_busy_stall: got %b expected 1", stall_ID); end
        n_chk++; if (fwd_data_1 !== 64'h31) begin n_fail++; $display("FAIL same_fwd1: got %h expected %h", fwd_data_1, 64'h31); end
        tick();
        idle(); wb_valid = 1; wb_rd = 9; wb_data = 64'h42; tick();
        idle(); rs1_ID = 9; rs1_use_ID = 1; rdata_1_ID = 64'h31; #1;
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL same_retired_stall: got %b expected 0", stall_ID); end
        tick();
    endtask

    task automatic test_x0();
        idle(); issue(5'd0, 1'b0);
        rs1_ID = 0; rs1_use_ID = 1; rdata_1_ID = 64'h55;
        rs2_ID = 0; rs2_use_ID = 1; rdata_2_ID = 64'h66;
        ex_valid = 1; ex_rd = 0; ex_data = 64'hFF; #1;
        n_chk++; if (fwd_data_1 !== 64'h0) begin n_fail++; $display("FAIL x0_fwd1: got %h expected 0", fwd_data_1); end
        n_chk++; if (fwd_data_2 !== 64'h0) begin n_fail++; $display("FAIL x0_fwd2: got %h expected 0", fwd_data_2); end
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b expected 0", stall_ID); end
        tick();
        idle(); rs1_ID = 3; rs1_use_ID = 1; rdata_1_ID = 64'h77; #1;
        n_chk++; if (fwd_data_1 !== 64'h77) begin n_fail++; $display("FAIL plain_fwd1: got %h expected %h", fwd_data_1, 64'h77); end
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL plain_stall: got %b expected 0", stall_ID); end
        tick();
    endtask

    task automatic test_async_reset();
        idle(); issue(5'd7, 1'b1); tick();
        idle(); rs2_ID = 7; rs2_use_ID = 1; rdata_2_ID = 64'h1234; #1;
        n_chk++; if (stall_ID !== 1'b1) begin n_fail++; $display("FAIL ar_pre_stall: got %b expected 1", stall_ID); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL ar_inreset_stall: got %b expected 0", stall_ID); end
        #1 rst = 1'b1;
        rs1_ID = 7; rs1_use_ID = 1; rdata_1_ID = 64'h4321;
        #1;
        n_chk++; if (fwd_data_1 !== 64'h4321) begin n_fail++; $display("FAIL ar_post_fwd1: got %h expected %h", fwd_data_1, 64'h4321); end
        n_chk++; if (stall_ID !== 1'b0) begin n_fail++; $display("FAIL ar_post_stall: got %b expected 0", stall_ID); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_distance2();
        test_load_use();
        test_same_cycle();
        test_x0();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule

`default_nettype wire
